// File: rtl/reg_file_sb.sv
// Integer register file with a per-register pending scoreboard for decode/issue hazard stalls.
// Optional same-cycle write-back forwarding: define REG_FILE_BYPASS_EN.
module reg_file_sb #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned AW      = $clog2(NREGS),
    parameter bit          R0_ZERO = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rs1,
    input  logic [AW-1:0]    issue_rs2,
    input  logic             issue_use_rs1,
    input  logic             issue_use_rs2,
    input  logic [AW-1:0]    issue_rd,
    input  logic             issue_wr_rd,
    output logic             issue_ready,
    output logic [XLEN-1:0]  rs1_data,
    output logic [XLEN-1:0]  rs2_data,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic [NREGS-1:0] busy_vec,
    output logic             wb_orphan
);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] r_busy;
    logic             r_orphan;

    logic             w_wb_live;
    logic             w_fire;
    logic             w_set_busy;
    logic [NREGS-1:0] w_busy_eff;
    logic             w_raw1;
    logic             w_raw2;
    logic             w_waw;

    // A write-back to the hard-wired zero register is dropped entirely.
    assign w_wb_live  = wb_en && !(R0_ZERO && (wb_rd == '0));
    assign w_fire     = issue_valid && issue_ready;
    assign w_set_busy = w_fire && issue_wr_rd && (issue_rd != '0);

    always_comb begin
        w_busy_eff = r_busy;
`ifdef REG_FILE_BYPASS_EN
        // The retiring register is about to be written, so it no longer blocks issue.
        if (w_wb_live) begin
            w_busy_eff[wb_rd] = 1'b0;
        end
`endif
    end

    assign w_raw1      = issue_use_rs1 && w_busy_eff[issue_rs1];
    assign w_raw2      = issue_use_rs2 && w_busy_eff[issue_rs2];
    assign w_waw       = issue_wr_rd   && w_busy_eff[issue_rd];
    assign issue_ready = !(w_raw1 || w_raw2 || w_waw);

    always_comb begin
        rs1_data = (R0_ZERO && (issue_rs1 == '0)) ? '0 : r_regs[issue_rs1];
        rs2_data = (R0_ZERO && (issue_rs2 == '0)) ? '0 : r_regs[issue_rs2];
`ifdef REG_FILE_BYPASS_EN
        if (wb_en && (wb_rd == issue_rs1) && (issue_rs1 != '0)) begin
            rs1_data = wb_data;
        end
        if (wb_en && (wb_rd == issue_rs2) && (issue_rs2 != '0)) begin
            rs2_data = wb_data;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[AW'(i)] <= '0;
            end
            r_busy   <= '0;
            r_orphan <= 1'b0;
        end else begin
            if (w_wb_live) begin
                r_regs[wb_rd] <= wb_data;
                r_busy[wb_rd] <= 1'b0;
                if (!r_busy[wb_rd]) begin
                    r_orphan <= 1'b1;
                end
            end
            // Issued after the write-back clear so a same-register set takes priority.
            if (w_set_busy) begin
                r_busy[issue_rd] <= 1'b1;
            end
        end
    end

    assign busy_vec  = r_busy;
    assign wb_orphan = r_orphan;

endmodule

// File: tb/tb_reg_file_sb.sv
// Table-driven directed bench for reg_file_sb; expectations follow REG_FILE_BYPASS_EN when defined.
module tb_reg_file_sb;

`ifdef REG_FILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic [4:0]  issue_rd;
    logic        issue_wr_rd;
    logic        issue_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] busy_vec;
    logic        wb_orphan;

    reg_file_sb #(.XLEN(32), .NREGS(32), .R0_ZERO(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rd      (issue_rd),
        .issue_wr_rd   (issue_wr_rd),
        .issue_ready   (issue_ready),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .wb_en         (wb_en),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .busy_vec      (busy_vec),
        .wb_orphan     (wb_orphan)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        rst;
        bit        iv;
        bit        u1;
        bit [4:0]  rs1;
        bit        u2;
        bit [4:0]  rs2;
        bit        wr;
        bit [4:0]  rd;
        bit        wbe;
        bit [4:0]  wbrd;
        bit [31:0] wbd;
        bit        e_ready;
        bit [31:0] e_rs1;
        bit [31:0] e_rs2;
        bit [31:0] e_busy;
        bit        e_orph;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic add(input bit r, input bit iv, input bit u1, input int rs1, input bit u2,
                       input int rs2, input bit wr, input int rd, input bit wbe, input int wbrd,
                       input bit [31:0] wbd, input bit er, input bit [31:0] e1, input bit [31:0] e2,
                       input bit [31:0] eb, input bit eo);
        vec_t v;
        v.rst = r;  v.iv = iv; v.u1 = u1; v.rs1 = 5'(rs1); v.u2 = u2; v.rs2 = 5'(rs2);
        v.wr = wr;  v.rd = 5'(rd); v.wbe = wbe; v.wbrd = 5'(wbrd); v.wbd = wbd;
        v.e_ready = er; v.e_rs1 = e1; v.e_rs2 = e2; v.e_busy = eb; v.e_orph = eo;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input bit [31:0] act, input bit [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL v%0d %s got=%h exp=%h", idx, name, act, exp);
        end
    endtask

    task automatic drive_idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_use_rs1 = 0; issue_use_rs2 = 0;
        issue_rd = 0; issue_wr_rd = 0; wb_en = 0; wb_rd = 0; wb_data = 0;
    endtask

    initial begin
        // Expectations are outputs during the cycle, before that cycle's rising edge.
        //   rst iv u1 rs1 u2 rs2 wr rd wbe wbrd wbd          ready  rs1            rs2            busy           orph
        add(1, 0, 0, 1,  0, 2,  0, 0, 0, 0,  32'h0,         1,     32'h0,         32'h0,         32'h0,         0); // 0 reset state
        add(1, 1, 0, 5,  0, 0,  1, 5, 0, 0,  32'h0,         1,     32'h0,         32'h0,         32'h0,         0); // 1 issue rd5
        add(1, 1, 1, 5,  0, 0,  0, 0, 0, 0,  32'h0,         0,     32'h0,         32'h0,         32'h20,        0); // 2 RAW on 5
        add(1, 1, 1, 5,  0, 0,  0, 0, 1, 5,  32'hDEADBEEF,  BYP,   BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 32'h20, 0); // 3 wb 5
        add(1, 1, 1, 5,  0, 0,  0, 0, 0, 0,  32'h0,         1,     32'hDEADBEEF,  32'h0,         32'h0,         0); // 4 bubble
        add(1, 1, 0, 0,  0, 0,  1, 7, 0, 0,  32'h0,         1,     32'h0,         32'h0,         32'h0,         0); // 5 issue rd7
        add(1, 1, 0, 0,  0, 0,  1, 7, 0, 0,  32'h0,         0,     32'h0,         32'h0,         32'h80,        0); // 6 WAW
        add(1, 1, 0, 0,  0, 0,  1, 7, 1, 7,  32'h77,        BYP,   32'h0,         32'h0,         32'h80,        0); // 7 wb7+issue7
        add(1, 0, 0, 7,  0, 0,  0, 0, 0, 0,  32'h0,         1,     32'h77,        32'h0,         BYP ? 32'h80 : 32'h0, 0); // 8
        add(1, !BYP, 0, 0, 0, 0, !BYP, 7, 0, 0, 32'h0,      1,     32'h0,         32'h0,         BYP ? 32'h80 : 32'h0, 0); // 9 re-arm 7
        add(1, 0, 0, 7,  0, 0,  0, 0, 1, 7,  32'h78,        1,     BYP ? 32'h78 : 32'h77, 32'h0, 32'h80,        0); // 10 retire 7
        add(1, 1, 0, 0,  0, 7,  1, 0, 0, 0,  32'h0,         1,     32'h0,         32'h78,        32'h0,         0); // 11 issue rd0
        add(1, 0, 0, 0,  0, 0,  0, 0, 1, 0,  32'h1234,      1,     32'h0,         32'h0,         32'h0,         0); // 12 wb x0
        add(1, 0, 0, 0,  0, 0,  0, 0, 0, 0,  32'h0,         1,     32'h0,         32'h0,         32'h0,         0); // 13 x0 still 0
        add(1, 0, 0, 0,  0, 0,  0, 0, 1, 9,  32'h99,        1,     32'h0,         32'h0,         32'h0,         0); // 14 orphan wb9
        add(1, 1, 0, 9,  0, 0,  1, 9, 0, 0,  32'h0,         1,     32'h99,        32'h0,         32'h0,         1); // 15 issue rd9
        add(1, 0, 0, 0,  0, 9,  0, 0, 1, 9,  32'hAA,        1,     32'h0,         BYP ? 32'hAA : 32'h99, 32'h200, 1); // 16 legal wb9
        add(1, 0, 0, 0,  0, 9,  0, 0, 0, 0,  32'h0,         1,     32'h0,         32'hAA,        32'h0,         1); // 17 sticky
        add(1, 1, 0, 0,  0, 0,  1, 3, 0, 0,  32'h0,         1,     32'h0,         32'h0,         32'h0,         1); // 18 issue rd3
        add(0, 1, 1, 3,  0, 0,  0, 0, 0, 0,  32'h0,         0,     32'h0,         32'h0,         32'h8,         1); // 19 reset
        add(1, 0, 0, 9,  0, 0,  0, 0, 1, 3,  32'h33,        1,     32'h0,         32'h0,         32'h0,         0); // 20 wb3 orphan
        add(1, 0, 0, 3,  0, 0,  0, 0, 0, 0,  32'h0,         1,     32'h33,        32'h0,         32'h0,         1); // 21
        add(1, 1, 0, 0,  0, 0,  1, 4, 0, 0,  32'h0,         1,     32'h0,         32'h0,         32'h0,         1); // 22 issue rd4
        add(1, 1, 0, 0,  1, 4,  0, 0, 0, 0,  32'h0,         0,     32'h0,         32'h0,         32'h10,        1); // 23 RAW rs2
        add(1, 1, 0, 4,  0, 4,  0, 0, 0, 0,  32'h0,         1,     32'h0,         32'h0,         32'h10,        1); // 24 unused srcs

        // Hand sequence: two reset cycles with the bus idle, then the table takes over.
        drive_idle();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  -1, busy_vec, 32'h0);
        chk("rst_orph",  -1, 32'(wb_orphan), 32'h0);
        chk("rst_ready", -1, 32'(issue_ready), 32'h1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst           = vecs[i].rst;
            issue_valid   = vecs[i].iv;
            issue_use_rs1 = vecs[i].u1;
            issue_rs1     = vecs[i].rs1;
            issue_use_rs2 = vecs[i].u2;
            issue_rs2     = vecs[i].rs2;
            issue_wr_rd   = vecs[i].wr;
            issue_rd      = vecs[i].rd;
            wb_en         = vecs[i].wbe;
            wb_rd         = vecs[i].wbrd;
            wb_data       = vecs[i].wbd;
            #2;
            chk("ready", i, 32'(issue_ready), 32'(vecs[i].e_ready));
            chk("rs1",   i, rs1_data, vecs[i].e_rs1);
            chk("rs2",   i, rs2_data, vecs[i].e_rs2);
            chk("busy",  i, busy_vec, vecs[i].e_busy);
            chk("orph",  i, 32'(wb_orphan), 32'(vecs[i].e_orph));
        end

        // Hand sequence: orphan set in vector 20 must survive idle cycles, then clear on reset.
        @(negedge clk);
        drive_idle();
        repeat (3) @(negedge clk);
        chk("orph_hold", -2, 32'(wb_orphan), 32'h1);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("orph_clr", -2, 32'(wb_orphan), 32'h0);
        chk("busy_clr", -2, busy_vec, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
